keypad_event_scanner: RTL and testbench

Parametrised matrix-keypad scanner that succeeds the fixed 4x3 scanner. It drives one-hot rows and samples the columns after a settle dwell. Each full scan is collapsed into a frame result, which is debounced over consecutive frames. The block emits clean press, release and auto-repeat event pulses plus a held key code, so the OMOK cursor/put logic consumes single-cycle events instead of raw levels.

---
 rtl/omok_keypad_pkg.sv | 19 +
 rtl/keypad_debounce.sv | 128 ++++++++++++
 rtl/keypad_event_scanner.sv | 118 +++++++++++
 tb/tb_keypad_event_scanner.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/omok_keypad_pkg.sv
// Shared types and key-code map for the OMOK keypad scanner.
package omok_keypad_pkg;

   typedef enum logic [1:0] {
      RES_NONE  = 2'd0,
      RES_KEY   = 2'd1,
      RES_MULTI = 2'd2
   } frame_res_e;

   // Codes for the default 4x3 layout, code = row*COLS + col
   localparam int KEY_UP    = 4;
   localparam int KEY_LEFT  = 6;
   localparam int KEY_PUT   = 7;
   localparam int KEY_RIGHT = 8;
   localparam int KEY_UNDO  = 9;
   localparam int KEY_DOWN  = 10;
   localparam int KEY_HASH  = 11;

endpackage

// File: rtl/keypad_debounce.sv
// Frame-rate debouncer: turns per-frame scan results into a stable key plus
// press/release/repeat pulses.
module keypad_debounce
   import omok_keypad_pkg::*;
#(
   parameter int KEY_W     = 4,
   parameter int DEBOUNCE  = 3,
   parameter int RPT_DELAY = 8,
   parameter int RPT_RATE  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             frame_stb,
   input  frame_res_e       frame_res,
   input  logic [KEY_W-1:0] frame_key,
   input  logic             rpt_en,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   output logic             press_pulse,
   output logic             release_pulse,
   output logic             key_event
);

   localparam int CNT_W   = $clog2(DEBOUNCE + 1);
   localparam int RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   logic             cand_valid_q, cand_valid_d;
   logic [KEY_W-1:0] cand_key_q, cand_key_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             stable_valid_q, stable_valid_d;
   logic [KEY_W-1:0] key_code_q, key_code_d;
   logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
   logic             rpt_armed_q, rpt_armed_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             event_q, event_d;
   logic             res_valid, change;

   always_comb begin
      cand_valid_d   = cand_valid_q;
      cand_key_d     = cand_key_q;
      cnt_d          = cnt_q;
      stable_valid_d = stable_valid_q;
      key_code_d     = key_code_q;
      rpt_cnt_d      = rpt_cnt_q;
      rpt_armed_d    = rpt_armed_q;
      press_d        = 1'b0;
      release_d      = 1'b0;
      event_d        = 1'b0;
      res_valid      = (frame_res == RES_KEY);
      change         = 1'b0;

      if (frame_stb) begin
         // Ghosted frames restart the run without disturbing the candidate
         if (frame_res == RES_MULTI) begin
            cnt_d = '0;
         end else if (res_valid == cand_valid_q && (!res_valid || frame_key == cand_key_q)) begin
            if (cnt_q != CNT_W'(DEBOUNCE)) cnt_d = cnt_q + 1'b1;
         end else begin
            cand_valid_d = res_valid;
            cand_key_d   = frame_key;
            cnt_d        = CNT_W'(1);
         end

         change = (cnt_d == CNT_W'(DEBOUNCE)) &&
                  ((cand_valid_d != stable_valid_q) ||
                   (cand_valid_d && cand_key_d != key_code_q));

         if (change) begin
            stable_valid_d = cand_valid_d;
            release_d      = stable_valid_q;
            rpt_cnt_d      = '0;
            rpt_armed_d    = 1'b0;
            if (cand_valid_d) begin
               press_d    = 1'b1;
               event_d    = 1'b1;
               key_code_d = cand_key_d;
            end
         end else if (stable_valid_q && rpt_en) begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
            if (rpt_cnt_d == (rpt_armed_q ? RPT_W'(RPT_RATE) : RPT_W'(RPT_DELAY))) begin
               event_d     = 1'b1;
               rpt_cnt_d   = '0;
               rpt_armed_d = 1'b1;
            end
         end
      end

      if (!rpt_en || !stable_valid_d) begin
         rpt_cnt_d   = '0;
         rpt_armed_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cand_valid_q   <= 1'b0;
         cand_key_q     <= '0;
         cnt_q          <= '0;
         stable_valid_q <= 1'b0;
         key_code_q     <= '0;
         rpt_cnt_q      <= '0;
         rpt_armed_q    <= 1'b0;
         press_q        <= 1'b0;
         release_q      <= 1'b0;
         event_q        <= 1'b0;
      end else begin
         cand_valid_q   <= cand_valid_d;
         cand_key_q     <= cand_key_d;
         cnt_q          <= cnt_d;
         stable_valid_q <= stable_valid_d;
         key_code_q     <= key_code_d;
         rpt_cnt_q      <= rpt_cnt_d;
         rpt_armed_q    <= rpt_armed_d;
         press_q        <= press_d;
         release_q      <= release_d;
         event_q        <= event_d;
      end
   end

   assign key_code      = key_code_q;
   assign key_valid     = stable_valid_q;
   assign press_pulse   = press_q;
   assign release_pulse = release_q;
   assign key_event     = event_q;

endmodule

// File: rtl/keypad_event_scanner.sv
// Matrix keypad scanner: one-hot row drive, per-frame column collection,
// and a frame-rate debouncer producing clean key events.
module keypad_event_scanner
   import omok_keypad_pkg::*;
#(
   parameter int ROWS      = 4,
   parameter int COLS      = 3,
   parameter int SCAN_DIV  = 4,
   parameter int DEBOUNCE  = 3,
   parameter int RPT_DELAY = 8,
   parameter int RPT_RATE  = 2,
   localparam int KEY_W    = $clog2(ROWS * COLS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [COLS-1:0]  key_col,
   input  logic             rpt_en,
   output logic [ROWS-1:0]  key_row,
   output logic [KEY_W-1:0] key_code,
   output logic             key_valid,
   output logic             press_pulse,
   output logic             release_pulse,
   output logic             key_event
);

   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   logic             active_q, active_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [DIV_W-1:0] dwell_q, dwell_d;
   logic [1:0]       hits_q, hits_d;
   logic [KEY_W-1:0] first_q, first_d;
   logic             sample, frame_end;
   frame_res_e       frame_res;
   logic [KEY_W-1:0] frame_key;

   always_comb begin
      active_d  = 1'b1;
      row_d     = row_q;
      dwell_d   = dwell_q;
      hits_d    = hits_q;
      first_d   = first_q;
      sample    = active_q && (dwell_q == DIV_W'(SCAN_DIV - 1));
      frame_end = sample && (row_q == ROW_W'(ROWS - 1));

      // active_q holds the scan off for the first edge so row 0 gets a full dwell
      if (active_q) begin
         if (sample) begin
            dwell_d = '0;
            row_d   = frame_end ? '0 : row_q + 1'b1;
         end else begin
            dwell_d = dwell_q + 1'b1;
         end
      end

      if (sample) begin
         for (int c = 0; c < COLS; c++) begin
            if (key_col[COLS-1-c]) begin
               if (hits_d == 2'd0) first_d = KEY_W'(int'(row_q) * COLS + c);
               if (hits_d != 2'd2) hits_d = hits_d + 2'd1;
            end
         end
      end

      frame_key = first_d;
      frame_res = RES_NONE;
      if (hits_d == 2'd1)      frame_res = RES_KEY;
      else if (hits_d == 2'd2) frame_res = RES_MULTI;

      if (frame_end) begin
         hits_d  = '0;
         first_d = '0;
      end
   end

   always_comb begin
      key_row = '0;
      for (int r = 0; r < ROWS; r++)
         key_row[ROWS-1-r] = active_q && (row_q == ROW_W'(r));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         active_q <= 1'b0;
         row_q    <= '0;
         dwell_q  <= '0;
         hits_q   <= '0;
         first_q  <= '0;
      end else begin
         active_q <= active_d;
         row_q    <= row_d;
         dwell_q  <= dwell_d;
         hits_q   <= hits_d;
         first_q  <= first_d;
      end
   end

   keypad_debounce #(
      .KEY_W     (KEY_W),
      .DEBOUNCE  (DEBOUNCE),
      .RPT_DELAY (RPT_DELAY),
      .RPT_RATE  (RPT_RATE)
   ) u_debounce (
      .clk           (clk),
      .rst           (rst),
      .frame_stb     (frame_end),
      .frame_res     (frame_res),
      .frame_key     (frame_key),
      .rpt_en        (rpt_en),
      .key_code      (key_code),
      .key_valid     (key_valid),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .key_event     (key_event)
   );

endmodule

// File: tb/tb_keypad_event_scanner.sv
// Scoreboard bench: a frame-level keypad model predicts every event pulse;
// a monitor matches DUT pulses against the queue.
module tb_keypad_event_scanner;
   import omok_keypad_pkg::*;

   localparam int ROWS = 4, COLS = 3, SCAN_DIV = 4, DEB = 3, DELAY = 8, RATE = 2;
   localparam int KEY_W = 4, NKEYS = ROWS * COLS, FRAME = ROWS * SCAN_DIV;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             rpt_en = 1'b0;
   logic [COLS-1:0]  key_col = '0;
   logic [ROWS-1:0]  key_row;
   logic [KEY_W-1:0] key_code;
   logic             key_valid, press_pulse, release_pulse, key_event;

   int cyc = 0;
   int checks = 0;
   int passed = 0;

   typedef struct {
      int cyc;
      bit press;
      bit rel;
      bit evt;
      bit valid;
      int code;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   // Reference model state: -1 means no key
   int m_stable = -1, m_cand = -1, m_run = 0, m_age = 0, m_code = 0;
   int keyset[7] = '{KEY_UP, KEY_LEFT, KEY_PUT, KEY_RIGHT, KEY_UNDO, KEY_DOWN, KEY_HASH};

   keypad_event_scanner #(
      .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEB),
      .RPT_DELAY(DELAY), .RPT_RATE(RATE)
   ) dut (
      .clk(clk), .rst(rst), .key_col(key_col), .rpt_en(rpt_en),
      .key_row(key_row), .key_code(key_code), .key_valid(key_valid),
      .press_pulse(press_pulse), .release_pulse(release_pulse), .key_event(key_event)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic logic [NKEYS-1:0] km(input int k);
      logic [NKEYS-1:0] m;
      m = '0;
      m[k] = 1'b1;
      return m;
   endfunction

   // One frame of keypad contents -> predicted pulses at the frame's end
   function automatic void model_frame(input logic [NKEYS-1:0] m, input logic ren, input int at);
      int n, first, res;
      exp_t e;
      n = 0;
      first = -1;
      for (int k = 0; k < NKEYS; k++)
         if (m[k]) begin
            if (first < 0) first = k;
            n++;
         end
      e.cyc = at; e.press = 0; e.rel = 0; e.evt = 0;
      if (n >= 2) m_run = 0;
      else begin
         res = (n == 0) ? -1 : first;
         if (res == m_cand) begin
            if (m_run < DEB) m_run++;
         end else begin
            m_cand = res;
            m_run  = 1;
         end
      end
      if (m_run == DEB && m_cand != m_stable) begin
         e.rel = (m_stable >= 0);
         if (m_cand >= 0) begin
            e.press = 1;
            e.evt   = 1;
            m_code  = m_cand;
         end
         m_stable = m_cand;
         m_age    = 0;
      end else if (m_stable >= 0 && ren) begin
         m_age++;
         if (m_age >= DELAY && (m_age - DELAY) % RATE == 0) e.evt = 1;
      end
      if (!ren) m_age = 0;
      e.valid = (m_stable >= 0);
      e.code  = m_code;
      if (e.press || e.rel || e.evt) sb.push_back(e);
   endfunction

   // Called on the negedge just after a frame's first edge; returns 16 cycles later
   task automatic run_frame(input logic [NKEYS-1:0] mask);
      int r;
      logic [ROWS-1:0] er;
      model_frame(mask, rpt_en, cyc + FRAME);
      for (int i = 0; i < FRAME; i++) begin
         r  = i / SCAN_DIV;
         er = ROWS'(1) << (ROWS - 1 - r);
         chk("key_row", key_row, er);
         for (int c = 0; c < COLS; c++) key_col[COLS-1-c] = mask[r*COLS+c];
         @(negedge clk);
      end
   endtask

   task automatic reset_mid(input logic [NKEYS-1:0] mask);
      for (int i = 0; i < 6; i++) begin
         for (int c = 0; c < COLS; c++) key_col[COLS-1-c] = mask[(i/SCAN_DIV)*COLS+c];
         @(negedge clk);
      end
      rst = 1'b0;
      #1;
      chk("rst_mid_outs", {key_row, key_code, key_valid, press_pulse, release_pulse, key_event}, 0);
      sb.delete();
      m_stable = -1; m_cand = -1; m_run = 0; m_age = 0; m_code = 0;
      repeat (2) @(negedge clk);
      chk("rst_hold_outs", {key_row, key_code, key_valid, press_pulse, release_pulse, key_event}, 0);
      rst = 1'b1;
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
         checks++;
         $display("FAIL missed_event: expected p/r/e=%b%b%b at cycle %0d, no pulse arrived",
                  sb[0].press, sb[0].rel, sb[0].evt, sb[0].cyc);
         void'(sb.pop_front());
      end
      if (press_pulse || release_pulse || key_event) begin
         if (sb.size() == 0 || sb[0].cyc != cyc) begin
            checks++;
            $display("FAIL unexpected_event: got p/r/e=%b%b%b code %0d at cycle %0d, expected none",
                     press_pulse, release_pulse, key_event, key_code, cyc);
         end else begin
            mon_e = sb.pop_front();
            chk("event", {press_pulse, release_pulse, key_event, key_valid, key_code},
                {mon_e.press, mon_e.rel, mon_e.evt, mon_e.valid, KEY_W'(mon_e.code)});
         end
      end
   end

   initial begin
      logic [NKEYS-1:0] mask;
      int kind, k1, k2, nfr;
      repeat (3) @(negedge clk);
      chk("reset_outs", {key_row, key_code, key_valid, press_pulse, release_pulse, key_event}, 0);
      rst = 1'b1;
      @(negedge clk);

      repeat (10) run_frame('0);

      repeat (5) run_frame(km(KEY_UP));
      repeat (4) run_frame('0);

      repeat (2) run_frame(km(KEY_UP));
      run_frame('0);
      repeat (3) run_frame(km(KEY_UP));
      repeat (4) run_frame('0);

      rpt_en = 1'b1;
      repeat (14) run_frame(km(KEY_RIGHT));
      repeat (4) run_frame('0);
      rpt_en = 1'b0;

      repeat (6) run_frame(km(KEY_LEFT) | km(KEY_RIGHT));
      repeat (4) run_frame(km(KEY_LEFT));
      repeat (4) run_frame('0);

      for (int s = 0; s < 40; s++) begin
         kind = $urandom_range(0, 9);
         k1   = (kind < 5) ? keyset[$urandom_range(0, 6)] : $urandom_range(0, NKEYS - 1);
         k2   = (k1 + 1 + $urandom_range(0, NKEYS - 2)) % NKEYS;
         if (kind < 3)      mask = '0;
         else if (kind < 8) mask = km(k1);
         else               mask = km(k1) | km(k2);
         nfr    = $urandom_range(1, 12);
         rpt_en = 1'($urandom_range(0, 1));
         for (int f = 0; f < nfr; f++) begin
            if ($urandom_range(0, 7) == 0) run_frame('0);
            else run_frame(mask);
         end
      end
      rpt_en = 1'b0;
      repeat (4) run_frame('0);

      repeat (2) run_frame(km(KEY_DOWN));
      reset_mid(km(KEY_DOWN));
      repeat (4) run_frame(km(KEY_DOWN));
      repeat (4) run_frame('0);

      repeat (2) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
